// File: rtl/field_packer.sv
`timescale 1ns/1ps
// field_packer: assembles FIELDS fields of FIELD_W bits into one packed word.
// Field k lands in bits [FIELD_W*k +: FIELD_W]. A word completes on the last
// slot or on in_last; unused upper slots read zero.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake, in_data field value, in_last ends word early
//   out_valid/out_ready   output handshake
//   out_data              packed word, out_count number of fields written (1..FIELDS)
//
// Build option: define FIELD_PACKER_SKID_EN to keep filling the next word
// while the previous one waits in the output register.
module field_packer #(
  parameter int unsigned FIELD_W = 10,
  parameter int unsigned FIELDS  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FIELD_W-1:0]         in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIELD_W*FIELDS-1:0]  out_data,
  output logic [2:0]                 out_count
);

  localparam int unsigned IdxW  = (FIELDS > 1) ? $clog2(FIELDS) : 1;
  localparam int unsigned WordW = FIELD_W * FIELDS;

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WordW-1:0]  asm_q, asm_d;
  logic [WordW-1:0]  out_data_q, out_data_d;
  logic [2:0]        out_count_q, out_count_d;
  logic [WordW-1:0]  filled;
  logic              complete;
  logic              accept;
  logic              xfer;

  // A field completes the word if it fills the top slot or carries in_last.
  assign complete  = (idx_q == IdxW'(FIELDS - 1)) || in_last;
  assign out_valid = (state_q == StHold);
  assign xfer      = out_valid && out_ready;

`ifdef FIELD_PACKER_SKID_EN
  // Only a completing field has to wait for the output register to free up;
  // a same-cycle drain lets it through with no bubble.
  assign in_ready = !(out_valid && !out_ready && complete);
`else
  assign in_ready = (state_q == StFill);
`endif

  assign accept    = in_valid && in_ready;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;

    filled = asm_q;
    filled[int'(idx_q) * FIELD_W +: FIELD_W] = in_data;

    if (xfer) begin
      state_d = StFill;
    end

    if (accept) begin
      if (complete) begin
        // Slots above idx_q are still zero because asm clears on each completion.
        out_data_d  = filled;
        out_count_d = 3'(idx_q) + 3'd1;
        asm_d       = '0;
        idx_d       = '0;
        state_d     = StHold;
      end else begin
        asm_d = filled;
        idx_d = idx_q + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      idx_q       <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

endmodule
